// File: rtl/branch_unit_if.sv
// branch_unit_if
//   Groups the branch request channel (execute -> branch unit) and the
//   redirect channel (branch unit -> fetch PC mux) into one bundle.
//   master : execute/fetch side (drives requests, consumes redirects)
//   slave  : branch_unit side
//   Signals:
//     br_valid/br_ready         branch request handshake
//     br_cond, br_pc, br_disp   condition code, branch PC, signed displacement
//     redirect_valid/ready      redirect handshake toward fetch
//     redirect_pc               taken target
//     flush                     squash younger instructions
interface branch_unit_if #(
  parameter int PC_W   = 16,
  parameter int DISP_W = 8
) ();
  logic              br_valid;
  logic              br_ready;
  logic [3:0]        br_cond;
  logic [PC_W-1:0]   br_pc;
  logic [DISP_W-1:0] br_disp;
  logic              redirect_valid;
  logic              redirect_ready;
  logic [PC_W-1:0]   redirect_pc;
  logic              flush;

  modport master (
    output br_valid, br_cond, br_pc, br_disp, redirect_ready,
    input  br_ready, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  br_valid, br_cond, br_pc, br_disp, redirect_ready,
    output br_ready, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_unit.sv
// branch_unit
//   Branch resolution unit: holds the architectural flag register {S,Z,C,V},
//   evaluates a 16-entry condition set, computes the PC-relative target and
//   redirects fetch through a valid/ready handshake, then holds a flush window
//   of FLUSH_CYCLES cycles over the wrong-path instructions.
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     flag_we, flag_in    flag register write enable / {S,Z,C,V} from ALU
//     flags_q             current flag register
//     taken_cnt           taken-branch count (saturating)
//     resolved_cnt        accepted-branch count (saturating)
//     bif (slave)         branch request + redirect channels, see branch_unit_if
//   Optional feature macro: BRANCH_STATS_EN enables the two statistics
//   counters; when undefined they are tied to zero and no counter flops exist.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | ready for a branch; not-taken branches resolve here
//   REDIRECT | redirect_valid and flush high, waiting for fetch to accept
//   FLUSH    | flush high for the remaining wrong-path cycles
module branch_unit #(
  parameter int PC_W         = 16,
  parameter int DISP_W       = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flag_we,
  input  logic [3:0]  flag_in,
  output logic [3:0]  flags_q,
  output logic [15:0] taken_cnt,
  output logic [15:0] resolved_cnt,
  branch_unit_if.slave bif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  // Counter is loaded with FLUSH_CYCLES-1 so the FLUSH state lasts exactly
  // FLUSH_CYCLES cycles; the zero case never enters FLUSH.
  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;

  logic [3:0]      eval_flags;
  logic            flag_s, flag_z, flag_c, flag_v;
  logic            taken;
  logic            accept;
  logic [PC_W-1:0] disp_ext;
  logic [PC_W-1:0] target;

  // Flag register: written in every state, never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'h0;
    else if (flag_we) flags_q <= flag_in;
  end

  // A flag write in the acceptance cycle is bypassed into evaluation.
  assign eval_flags = flag_we ? flag_in : flags_q;
  assign flag_s     = eval_flags[3];
  assign flag_z     = eval_flags[2];
  assign flag_c     = eval_flags[1];
  assign flag_v     = eval_flags[0];

  always_comb begin
    taken = 1'b0;
    case (bif.br_cond)
      4'h0:    taken = flag_z;
      4'h1:    taken = flag_s ^ flag_v;
      4'h2:    taken = flag_z | (flag_s ^ flag_v);
      4'h3:    taken = ~flag_z;
      4'h4:    taken = 1'b1;
      4'h5:    taken = ~(flag_s ^ flag_v);
      4'h6:    taken = ~flag_z & ~(flag_s ^ flag_v);
      4'h7:    taken = flag_c;
      4'h8:    taken = ~flag_c;
      4'h9:    taken = flag_c & ~flag_z;
      4'hA:    taken = flag_s;
      4'hB:    taken = ~flag_s;
      4'hC:    taken = flag_v;
      4'hD:    taken = ~flag_v;
      default: taken = 1'b0;
    endcase
  end

  // Sign extension comes from the signed size cast; the sum wraps modulo 2^PC_W.
  assign disp_ext = PC_W'($signed(bif.br_disp));
  assign target   = bif.br_pc + disp_ext + PC_W'(1);

  assign bif.br_ready       = (state_q == IDLE);
  assign accept             = bif.br_valid & bif.br_ready;
  assign bif.redirect_valid = (state_q == REDIRECT);
  assign bif.flush          = (state_q == REDIRECT) | (state_q == FLUSH);
  assign bif.redirect_pc    = redirect_pc_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (accept && taken) begin
          state_d       = REDIRECT;
          redirect_pc_d = target;
        end
      end
      REDIRECT: begin
        if (bif.redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] resolved_cnt_q, resolved_cnt_d;

  // Saturate at all-ones rather than wrapping.
  always_comb begin
    taken_cnt_d    = taken_cnt_q;
    resolved_cnt_d = resolved_cnt_q;
    if (accept) begin
      if (resolved_cnt_q != 16'hFFFF) resolved_cnt_d = resolved_cnt_q + 16'd1;
      if (taken && (taken_cnt_q != 16'hFFFF)) taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q    <= 16'h0;
      resolved_cnt_q <= 16'h0;
    end else begin
      taken_cnt_q    <= taken_cnt_d;
      resolved_cnt_q <= resolved_cnt_d;
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign resolved_cnt = resolved_cnt_q;
`else
  assign taken_cnt    = 16'h0;
  assign resolved_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_we = 1'b0;
  logic [3:0]  flag_in = 4'h0;
  logic [3:0]  flags_q;
  logic [15:0] taken_cnt;
  logic [15:0] resolved_cnt;

  branch_unit_if #(.PC_W(16), .DISP_W(8)) bif ();

  branch_unit #(.PC_W(16), .DISP_W(8), .FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flag_we      (flag_we),
    .flag_in      (flag_in),
    .flags_q      (flags_q),
    .taken_cnt    (taken_cnt),
    .resolved_cnt (resolved_cnt),
    .bif          (bif)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sb_q[$];
  logic [3:0]  flags_m = 4'h0;
  logic        tk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_taken(input logic [3:0] cond, input logic [3:0] f);
    logic s, z, c, v;
    s = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'h0: return z;
      4'h1: return s != v;
      4'h2: return z || (s != v);
      4'h3: return !z;
      4'h4: return 1'b1;
      4'h5: return s == v;
      4'h6: return !z && (s == v);
      4'h7: return c;
      4'h8: return !c;
      4'h9: return c && !z;
      4'hA: return s;
      4'hB: return !s;
      4'hC: return v;
      4'hD: return !v;
      default: return 1'b0;
    endcase
  endfunction

  // Redirect monitor: handshake seen mid-cycle completes at the next edge.
  always @(negedge clk) begin
    if (rst_n && bif.redirect_valid && bif.redirect_ready) begin
      check("rdr_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check("redirect_pc", 32'(bif.redirect_pc), 32'(sb_q.pop_front()));
    end
  end

  task automatic set_flags(input logic [3:0] f);
    @(posedge clk); #1;
    flag_we = 1'b1; flag_in = f; flags_m = f;
    @(posedge clk); #1;
    flag_we = 1'b0;
    check("flags_q", 32'(flags_q), 32'(f));
  endtask

  task automatic drive_branch(input logic [3:0] cond, input logic [15:0] pc, input logic [7:0] disp,
                              input logic we, input logic [3:0] fin, output logic taken_o);
    logic [15:0] tgt;
    @(posedge clk); #1;
    bif.br_valid = 1'b1; bif.br_cond = cond; bif.br_pc = pc; bif.br_disp = disp;
    flag_we = we; flag_in = fin;
    taken_o = model_taken(cond, we ? fin : flags_m);
    if (we) flags_m = fin;
    tgt = pc + 16'd1 + {{8{disp[7]}}, disp};
    if (taken_o) sb_q.push_back(tgt);
    @(posedge clk); #1;
    bif.br_valid = 1'b0; flag_we = 1'b0;
    check("taken", 32'(bif.redirect_valid), 32'(taken_o));
    check("br_ready_post", 32'(bif.br_ready), 32'(!taken_o));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !bif.br_ready; i++) begin
      @(posedge clk); #1;
    end
    check("idle_reached", 32'(bif.br_ready), 32'd1);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    bif.br_valid = 1'b0; bif.br_cond = 4'h0; bif.br_pc = 16'h0; bif.br_disp = 8'h0;
    bif.redirect_ready = 1'b0;

    // Reset values
    #2;
    check("rst_flags", 32'(flags_q), 32'd0);
    check("rst_rvalid", 32'(bif.redirect_valid), 32'd0);
    check("rst_flush", 32'(bif.flush), 32'd0);
    check("rst_rpc", 32'(bif.redirect_pc), 32'd0);
    check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    check("rst_resolved_cnt", 32'(resolved_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_br_ready", 32'(bif.br_ready), 32'd1);

    // Full condition table, redirect always accepted
    bif.redirect_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        set_flags(4'(f));
        drive_branch(4'(c), 16'($urandom), 8'($urandom), 1'b0, 4'h0, tk);
        wait_idle();
      end
    end

    // Flag bypass in the acceptance cycle
    set_flags(4'h0);
    drive_branch(4'h0, 16'h0200, 8'h10, 1'b1, 4'b0100, tk);
    check("bypass_taken", 32'(tk), 32'd1);
    check("bypass_flags", 32'(flags_q), 32'h4);
    wait_idle();

    // Redirect held under back-pressure, then exact flush window
    bif.redirect_ready = 1'b0;
    drive_branch(4'h4, 16'h0010, 8'hF0, 1'b0, 4'h0, tk);
    for (int i = 0; i < 3; i++) begin
      check("hold_rpc", 32'(bif.redirect_pc), 32'h0001);
      check("hold_rvalid", 32'(bif.redirect_valid), 32'd1);
      check("hold_br_ready", 32'(bif.br_ready), 32'd0);
      check("hold_flush", 32'(bif.flush), 32'd1);
      @(posedge clk); #1;
    end
    bif.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bif.redirect_ready = 1'b0;
    check("flush1", 32'(bif.flush), 32'd1);
    check("flush1_rvalid", 32'(bif.redirect_valid), 32'd0);
    @(posedge clk); #1;
    check("flush2", 32'(bif.flush), 32'd1);
    @(posedge clk); #1;
    check("flush_end", 32'(bif.flush), 32'd0);
    check("flush_end_ready", 32'(bif.br_ready), 32'd1);
    check("sb_after_hs", 32'(sb_q.size()), 32'd0);

    // Target wrap-around
    bif.redirect_ready = 1'b1;
    drive_branch(4'h4, 16'hFFFF, 8'h01, 1'b0, 4'h0, tk);
    wait_idle();

    // Not-taken NE with Z set
    set_flags(4'b0100);
    drive_branch(4'h3, 16'h1234, 8'h05, 1'b0, 4'h0, tk);
    check("nt_ready_hold", 32'(bif.br_ready), 32'd1);
    check("nt_rvalid", 32'(bif.redirect_valid), 32'd0);

`ifndef BRANCH_STATS_EN
    check("nostats_taken", 32'(taken_cnt), 32'd0);
    check("nostats_resolved", 32'(resolved_cnt), 32'd0);
`endif

    // Reset in the middle of the flush window
    drive_branch(4'h4, 16'h0100, 8'h05, 1'b0, 4'h0, tk);
    @(posedge clk); #1;
    check("midrst_pre_flush", 32'(bif.flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_flush", 32'(bif.flush), 32'd0);
    check("midrst_rvalid", 32'(bif.redirect_valid), 32'd0);
    check("midrst_flags", 32'(flags_q), 32'd0);
    flags_m = 4'h0;
    sb_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 32'(bif.br_ready), 32'd1);

`ifdef BRANCH_STATS_EN
    check("stats_rst_taken", 32'(taken_cnt), 32'd0);
    check("stats_rst_resolved", 32'(resolved_cnt), 32'd0);
    // Back-to-back not-taken accepts drive resolved_cnt into saturation.
    bif.br_valid = 1'b1; bif.br_cond = 4'hE;
    repeat (65537) @(posedge clk);
    #1 bif.br_valid = 1'b0;
    check("stats_sat_resolved", 32'(resolved_cnt), 32'hFFFF);
    check("stats_sat_taken", 32'(taken_cnt), 32'd0);
    drive_branch(4'h4, 16'h0040, 8'h02, 1'b0, 4'h0, tk);
    wait_idle();
    drive_branch(4'h4, 16'h0080, 8'hFE, 1'b0, 4'h0, tk);
    wait_idle();
    check("stats_taken2", 32'(taken_cnt), 32'd2);
    check("stats_resolved_hold", 32'(resolved_cnt), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
